sprite_path_mover: RTL
======================

# sprite_path_mover

Parametrised sprite movement controller for the isometric playfield. It paces move requests with an internal tick and validates each one-step diagonal move against a runtime-programmable table of diagonal path segments. It then sequences the sprite drawer through an erase-background / draw-character handshake. It sits between the button/direction input logic and the sprite drawer FSM, and supersedes the fixed-path mover by moving the path geometry out of RTL into a writable table.

## Interface

Parameters:
- XW, 9: x coordinate width.
- YW, 8: y coordinate width.
- NUM_SEG, 8: segment table depth (≥1); AW = max(1, $clog2(NUM_SEG)).
- STEP, 1: pixels moved per axis per step.
- TICK_DIV, 6250000: clock cycles per move tick (≥1).
- START_X, 95 / START_Y, 221: reset position.
- MAX_X, 319 / MAX_Y, 239: largest legal coordinate.
- TP_X, 120 / TP_Y, 196 / TP_DX, 126 / TP_DY, 68: teleport trigger point and destination (TELEPORT_EN only).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- move  in  1  move request (level or pulse).
- dir  in  2  direction: 0 = (+x,+y), 1 = (−x,+y), 2 = (+x,−y), 3 = (−x,−y).
- seg_we  in  1  segment table write strobe.
- seg_addr  in  AW  segment index.
- seg_data  in  2+3·XW  {valid, slope, c[XW], xmin[XW], xmax[XW]}.
- doneBG  in  1  drawer finished background erase.
- doneChar  in  1  drawer finished character draw.
- xCoordinate  out  XW  current sprite x.
- yCoordinate  out  YW  current sprite y.
- drawBG  out  1  erase request, held high in ERASE.
- drawChar  out  1  draw request, held high in DRAW.
- busy  out  1  high in any state other than IDLE.
- cfg_ready  out  1  high in IDLE; table writes accepted only then.
- moved  out  1  one-cycle pulse in UPDATE.
- rejected  out  1  one-cycle pulse when a request fails validation.

## Operation

- Tick: a free-running counter counts 0..TICK_DIV−1; tick=1 when the count equals TICK_DIV−1. The counter is zeroed on reset.
- Request latch:
  - Any cycle with move=1 sets pend and loads dir_q←dir, so the last request wins.
  - Acceptance clears pend unless move=1 in that same cycle.
- IDLE: on tick && (move || pend), the block:
  - registers nx = x ± STEP and ny = y ± STEP per dir (using dir if move=1, else dir_q), computed signed at XW+1 / YW+1 bits;
  - sets idx←0 and enters CHECK.
- CHECK evaluates one table entry per cycle, in priority order:
  1. nx<1, ny<1, nx>MAX_X or ny>MAX_Y: pulse rejected, go to IDLE.
  2. Teleport hit (TELEPORT_EN): accept.
  3. seg[idx] matches: accept. A match requires valid=1 and xmin≤nx≤xmax, plus nx+ny==c when slope=0 or nx−ny==c when slope=1. The comparison is exact at XW+1 bits.
  4. idx==NUM_SEG−1: pulse rejected, go to IDLE.
  5. Otherwise idx++.
- Accept → ERASE.
- ERASE: drawBG=1 until doneBG=1 is sampled, then UPDATE.
- UPDATE: x←nx, y←ny (or TP_DX/TP_DY on teleport); moved=1; go to DRAW.
- DRAW: drawChar=1 until doneChar=1 is sampled, then IDLE.
- doneBG and doneChar are ignored outside ERASE and DRAW respectively.
- Table: seg_we with cfg_ready=1 writes seg[seg_addr]. Writes while busy, and writes to seg_addr≥NUM_SEG, are dropped.

## Timing

- Reset values:
  - xCoordinate=START_X, yCoordinate=START_Y.
  - drawBG, drawChar, busy, moved, rejected, pend = 0; cfg_ready=1.
  - All segment valid bits cleared; state=IDLE.
- Reset mid-operation returns to IDLE next edge. No further drawBG/drawChar are issued.
- All outputs are registered state decodes or registers.
- Latency:
  - Accept at edge t puts the FSM in CHECK at t+1.
  - A match at entry k gives ERASE at t+k+2.
  - doneBG sampled at edge e gives UPDATE in cycle e+1 and DRAW at e+2.
  - Position updates at the edge ending UPDATE.
- Minimum full move: 1 + k+1 + 1 + 1 + 1 cycles with doneBG and doneChar returned immediately.
- Requests during busy are latched in pend and served at the first tick in IDLE. At most one request is queued.
- A done input already high on entry to ERASE/DRAW completes that state in one cycle.

## Configuration

- TELEPORT_EN defined: a step landing exactly on (TP_X,TP_Y) is valid regardless of the table, and the sprite is placed at (TP_DX,TP_DY).
- TELEPORT_EN undefined: the TP_* parameters are unused, and (TP_X,TP_Y) is validated like any other point.

## Test plan

- TICK_DIV=4; seg0={1,0,316,95,120}; move=1, dir=2 → CHECK matches at idx0, then drawBG, then doneBG, then x=96, y=220, moved pulse, drawChar, then doneChar, then IDLE.
- Same table, dir=1 from (95,221) → nx=94<xmin; all 8 entries scanned; rejected pulse 8 cycles after CHECK entry; position unchanged.
- Sprite at x=1, dir=1 → out-of-bounds reject in the first CHECK cycle; no scan.
- TELEPORT_EN, sprite at (119,197), dir=2 → (126,68) after UPDATE. Without the macro → (120,196) via seg0.
- move pulsed for 1 cycle during DRAW → pend held; served at the first tick after returning to IDLE. A second pulse while busy does not queue a second move.
- seg_we asserted during ERASE → entry unchanged. resetn=0 during DRAW → position = (95,221), drawChar=0, table invalidated.

Source files
------------

// File: rtl/sprite_path_mover.sv
// rtl/sprite_path_mover.sv - tick-paced diagonal sprite mover validated against a writable segment table
// Optional TELEPORT_EN: a step onto (TP_X,TP_Y) is always legal and relocates the sprite to (TP_DX,TP_DY).
module sprite_path_mover #(
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int NUM_SEG  = 8,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 6250000,
    parameter int START_X  = 95,
    parameter int START_Y  = 221,
    parameter int MAX_X    = 319,
    parameter int MAX_Y    = 239,
    parameter int TP_X     = 120,
    parameter int TP_Y     = 196,
    parameter int TP_DX    = 126,
    parameter int TP_DY    = 68,
    localparam int AW      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
    localparam int SW      = 2 + 3 * XW
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          move,
    input  logic [1:0]    dir,
    input  logic          seg_we,
    input  logic [AW-1:0] seg_addr,
    input  logic [SW-1:0] seg_data,
    input  logic          doneBG,
    input  logic          doneChar,
    output logic [XW-1:0] xCoordinate,
    output logic [YW-1:0] yCoordinate,
    output logic          drawBG,
    output logic          drawChar,
    output logic          busy,
    output logic          cfg_ready,
    output logic          moved,
    output logic          rejected
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]     TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [XW:0] STEP_X   = (XW+1)'(STEP);
    localparam logic signed [YW:0] STEP_Y   = (YW+1)'(STEP);
    localparam logic signed [XW:0] ONE_X    = (XW+1)'(1);
    localparam logic signed [YW:0] ONE_Y    = (YW+1)'(1);
    localparam logic signed [XW:0] MAX_XS   = (XW+1)'(MAX_X);
    localparam logic signed [YW:0] MAX_YS   = (YW+1)'(MAX_Y);
    localparam logic [AW-1:0]      LAST_IDX = AW'(NUM_SEG - 1);
`ifdef TELEPORT_EN
    localparam bit TP_ON = 1'b1;
`else
    localparam bit TP_ON = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ERASE, S_UPDATE, S_DRAW} state_t;

    state_t               state;
    logic [CW-1:0]        tick_cnt;
    logic                 tick;
    logic                 pend;
    logic [1:0]           dir_q;
    logic [1:0]           dir_use;
    logic                 accept;
    logic signed [XW:0]   xs;
    logic signed [YW:0]   ys;
    logic signed [XW:0]   nx;
    logic signed [YW:0]   ny;
    logic [AW-1:0]        idx;
    logic                 tp_q;

    logic [SW-2:0]        seg_geom [NUM_SEG];
    logic [NUM_SEG-1:0]   seg_valid;
    logic                 wr_ok;

    logic [SW-2:0]        cur;
    logic                 cur_slope;
    logic [XW-1:0]        cur_c;
    logic [XW-1:0]        cur_xmin;
    logic [XW-1:0]        cur_xmax;
    logic signed [XW:0]   nyx;
    logic signed [XW:0]   sum;
    logic signed [XW:0]   diff;
    logic                 in_x;
    logic                 seg_hit;
    logic                 tp_hit;
    logic                 oob;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clock) begin
        if (!resetn || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign accept  = (state == S_IDLE) && tick && (move || pend);
    assign dir_use = move ? dir : dir_q;

    // A request arriving in the accepting cycle stays pending on purpose: move may be a level.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pend  <= 1'b0;
            dir_q <= 2'd0;
        end else if (move) begin
            pend  <= 1'b1;
            dir_q <= dir;
        end else if (accept) begin
            pend  <= 1'b0;
        end
    end

    assign wr_ok = seg_we && cfg_ready && ({1'b0, seg_addr} < (AW+1)'(NUM_SEG));

    always_ff @(posedge clock) begin
        if (!resetn)
            seg_valid <= '0;
        else if (wr_ok)
            seg_valid[seg_addr] <= seg_data[SW-1];
    end

    always_ff @(posedge clock) begin
        if (wr_ok)
            seg_geom[seg_addr] <= seg_data[SW-2:0];
    end

    assign xs = $signed({1'b0, xCoordinate});
    assign ys = $signed({1'b0, yCoordinate});

    assign cur       = seg_geom[idx];
    assign cur_slope = cur[SW-2];
    assign cur_c     = cur[3*XW-1:2*XW];
    assign cur_xmin  = cur[2*XW-1:XW];
    assign cur_xmax  = cur[XW-1:0];

    // Line equations are evaluated exactly at XW+1 bits; negative differences never equal an unsigned c.
    assign nyx     = (XW+1)'(ny);
    assign sum     = nx + nyx;
    assign diff    = nx - nyx;
    assign in_x    = (nx >= $signed({1'b0, cur_xmin})) && (nx <= $signed({1'b0, cur_xmax}));
    assign seg_hit = seg_valid[idx] && in_x &&
                     (cur_slope ? (diff == $signed({1'b0, cur_c})) : (sum == $signed({1'b0, cur_c})));
    assign tp_hit  = TP_ON && (nx == (XW+1)'(TP_X)) && (ny == (YW+1)'(TP_Y));
    assign oob     = (nx < ONE_X) || (ny < ONE_Y) || (nx > MAX_XS) || (ny > MAX_YS);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            xCoordinate <= XW'(START_X);
            yCoordinate <= YW'(START_Y);
            drawBG      <= 1'b0;
            drawChar    <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
            moved       <= 1'b0;
            rejected    <= 1'b0;
            nx          <= '0;
            ny          <= '0;
            idx         <= '0;
            tp_q        <= 1'b0;
        end else begin
            moved    <= 1'b0;
            rejected <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        nx        <= dir_use[0] ? xs - STEP_X : xs + STEP_X;
                        ny        <= dir_use[1] ? ys - STEP_Y : ys + STEP_Y;
                        idx       <= '0;
                        state     <= S_CHECK;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (oob || (!tp_hit && !seg_hit && idx == LAST_IDX)) begin
                        rejected  <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (tp_hit || seg_hit) begin
                        tp_q   <= tp_hit;
                        state  <= S_ERASE;
                        drawBG <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_ERASE: begin
                    if (doneBG) begin
                        drawBG <= 1'b0;
                        moved  <= 1'b1;
                        state  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    xCoordinate <= tp_q ? XW'(TP_DX) : nx[XW-1:0];
                    yCoordinate <= tp_q ? YW'(TP_DY) : ny[YW-1:0];
                    drawChar    <= 1'b1;
                    state       <= S_DRAW;
                end
                S_DRAW: begin
                    if (doneChar) begin
                        drawChar  <= 1'b0;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    drawBG    <= 1'b0;
                    drawChar  <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
